// File: rtl/sysid_info_regs.sv
// System-identification register bank (Avalon-MM slave, fixed 1-cycle read latency).
// Optional seconds counter and heartbeat output are enabled by defining SYSID_HEARTBEAT_EN.
`timescale 1ns/1ps
module sysid_info_regs #(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] BUILD_TS    = 32'h0000_0000,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned UPTIME_W    = 64,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        heartbeat
);

    localparam logic [31:0] CLK_FREQ_WORD = 32'(CLK_FREQ_HZ);

    logic [UPTIME_W-1:0] uptime_q, uptime_d;
    logic [31:0]         snap_q, snap_d;
    logic [31:0]         scratch_q, scratch_d;
    logic                freeze_q, freeze_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                rdv_q, rdv_d;
    logic [63:0]         uptime_ext;
    logic [31:0]         seconds_word;
    logic                rd_en;
    logic                clear;

    // A write in the same cycle as a read takes precedence and the read is dropped.
    assign rd_en = read && !write;
    assign clear = write && (address == 3'd7) && writedata[0];

    always_comb begin
        uptime_ext = '0;
        uptime_ext[UPTIME_W-1:0] = uptime_q;

        uptime_d = uptime_q;
        if (!freeze_q)
            uptime_d = uptime_q + UPTIME_W'(1);
        if (clear)
            uptime_d = '0;

        // Reading the low word latches the matching high word so the pair is coherent.
        snap_d = snap_q;
        if (rd_en && (address == 3'd2))
            snap_d = uptime_ext[63:32];
        if (clear)
            snap_d = '0;

        scratch_d = scratch_q;
        if (write && (address == 3'd4)) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b])
                    scratch_d[8*b +: 8] = writedata[8*b +: 8];
        end

        freeze_d = freeze_q;
        if (write && (address == 3'd7))
            freeze_d = writedata[1];

        rdv_d      = rd_en;
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                3'd0:    readdata_d = SYSTEM_ID;
                3'd1:    readdata_d = BUILD_TS;
                3'd2:    readdata_d = uptime_q[31:0];
                3'd3:    readdata_d = snap_q;
                3'd4:    readdata_d = scratch_q;
                3'd5:    readdata_d = CLK_FREQ_WORD;
                3'd6:    readdata_d = seconds_word;
                default: readdata_d = {30'd0, freeze_q, 1'b0};
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_q   <= '0;
            snap_q     <= '0;
            scratch_q  <= SCRATCH_RST;
            freeze_q   <= 1'b0;
            readdata_q <= '0;
            rdv_q      <= 1'b0;
        end else begin
            uptime_q   <= uptime_d;
            snap_q     <= snap_d;
            scratch_q  <= scratch_d;
            freeze_q   <= freeze_d;
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

`ifdef SYSID_HEARTBEAT_EN
    localparam logic [31:0] PRESC_MAX = 32'(CLK_FREQ_HZ - 1);

    logic [31:0] prescaler_q, prescaler_d;
    logic [31:0] seconds_q, seconds_d;
    logic        hb_q, hb_d;

    always_comb begin
        prescaler_d = prescaler_q;
        seconds_d   = seconds_q;
        hb_d        = hb_q;
        if (!freeze_q) begin
            if (prescaler_q == PRESC_MAX) begin
                prescaler_d = '0;
                seconds_d   = seconds_q + 32'd1;
                hb_d        = !hb_q;
            end else begin
                prescaler_d = prescaler_q + 32'd1;
            end
        end
        // Heartbeat phase is deliberately left untouched by CLEAR.
        if (clear) begin
            prescaler_d = '0;
            seconds_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_q <= '0;
            seconds_q   <= '0;
            hb_q        <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            seconds_q   <= seconds_d;
            hb_q        <= hb_d;
        end
    end

    assign seconds_word = seconds_q;
    assign heartbeat    = hb_q;
`else
    assign seconds_word = 32'd0;
    assign heartbeat    = 1'b0;
`endif

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed testbench for sysid_info_regs; heartbeat checks follow SYSID_HEARTBEAT_EN.
`timescale 1ns/1ps
module tb_sysid_info_regs;

    localparam logic [31:0] ID  = 32'hC0FF_EE01;
    localparam logic [31:0] TS  = 32'h6543_2100;
    localparam logic [31:0] SRST = 32'h5A5A_0000;

    logic        clock, reset, read, write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata, readdata2;
    logic        readdatavalid, readdatavalid2, heartbeat, heartbeat2;

    int nvec  = 0;
    int nfail = 0;

    sysid_info_regs #(.SYSTEM_ID(ID), .BUILD_TS(TS), .CLK_FREQ_HZ(10),
                      .UPTIME_W(64), .SCRATCH_RST(SRST)) dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
        .readdatavalid(readdatavalid), .heartbeat(heartbeat));

    sysid_info_regs #(.SYSTEM_ID(ID), .BUILD_TS(TS), .CLK_FREQ_HZ(10),
                      .UPTIME_W(33), .SCRATCH_RST(SRST)) dut2 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata2),
        .readdatavalid(readdatavalid2), .heartbeat(heartbeat2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0;
        d    = readdata;
        v    = readdatavalid;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        reset = 1'b1;
        idle(3);
        nvec++; if (readdata !== 32'h0) begin nfail++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
        nvec++; if (readdatavalid !== 1'b0) begin nfail++; $display("FAIL reset_rdv got=%b exp=0", readdatavalid); end
        nvec++; if (heartbeat !== 1'b0) begin nfail++; $display("FAIL reset_heartbeat got=%b exp=0", heartbeat); end
        reset = 1'b0;
        rd(3'd2, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL reset_uptime got=%h exp=%h", d, 32'h0); end
        rd(3'd4, d, v);
        nvec++; if (d !== SRST) begin nfail++; $display("FAIL reset_scratch got=%h exp=%h", d, SRST); end
        rd(3'd7, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
        rd(3'd6, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL reset_seconds got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_id();
        logic [31:0] d;
        logic v;
        rd(3'd0, d, v);
        nvec++; if (d !== ID) begin nfail++; $display("FAIL id got=%h exp=%h", d, ID); end
        nvec++; if (v !== 1'b1) begin nfail++; $display("FAIL id_rdv got=%b exp=1", v); end
        rd(3'd1, d, v);
        nvec++; if (d !== TS) begin nfail++; $display("FAIL ts got=%h exp=%h", d, TS); end
        rd(3'd5, d, v);
        nvec++; if (d !== 32'd10) begin nfail++; $display("FAIL clkfreq got=%h exp=%h", d, 32'd10); end
        nvec++; if (v !== 1'b1) begin nfail++; $display("FAIL clkfreq_rdv got=%b exp=1", v); end
        idle(1);
        nvec++; if (readdatavalid !== 1'b0) begin nfail++; $display("FAIL rdv_pulse got=%b exp=0", readdatavalid); end
        nvec++; if (readdata !== 32'd10) begin nfail++; $display("FAIL readdata_hold got=%h exp=%h", readdata, 32'd10); end
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        logic v;
        wr(3'd4, 32'hDEAD_BEEF, 4'hF);
        rd(3'd4, d, v);
        nvec++; if (d !== 32'hDEAD_BEEF) begin nfail++; $display("FAIL scratch_full got=%h exp=%h", d, 32'hDEAD_BEEF); end
        wr(3'd4, 32'h0000_1200, 4'b0010);
        rd(3'd4, d, v);
        nvec++; if (d !== 32'hDEAD_12EF) begin nfail++; $display("FAIL scratch_lane got=%h exp=%h", d, 32'hDEAD_12EF); end
        wr(3'd4, 32'hFFFF_FFFF, 4'h0);
        rd(3'd4, d, v);
        nvec++; if (d !== 32'hDEAD_12EF) begin nfail++; $display("FAIL scratch_be0 got=%h exp=%h", d, 32'hDEAD_12EF); end
    endtask

    task automatic test_ro_and_ctrl_bits();
        logic [31:0] d;
        logic v;
        wr(3'd0, 32'h1234_5678, 4'hF);
        rd(3'd0, d, v);
        nvec++; if (d !== ID) begin nfail++; $display("FAIL ro_write got=%h exp=%h", d, ID); end
        wr(3'd7, 32'hFFFF_FFF8, 4'hF);
        rd(3'd7, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL ctrl_upper got=%h exp=%h", d, 32'h0); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        logic v;
        dut.uptime_q = 64'h0000_0000_FFFF_FFFF;
        rd(3'd2, d, v);
        nvec++; if (d !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL snap_lo got=%h exp=%h", d, 32'hFFFF_FFFF); end
        rd(3'd3, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL snap_hi got=%h exp=%h", d, 32'h0); end
        rd(3'd2, d, v);
        nvec++; if (d !== 32'h1) begin nfail++; $display("FAIL snap_lo2 got=%h exp=%h", d, 32'h1); end
        rd(3'd3, d, v);
        nvec++; if (d !== 32'h1) begin nfail++; $display("FAIL snap_hi2 got=%h exp=%h", d, 32'h1); end
    endtask

    task automatic test_freeze_clear();
        logic [31:0] d, a;
        logic v;
        wr(3'd7, 32'h2, 4'hF);
        idle(10);
        rd(3'd2, a, v);
        rd(3'd2, d, v);
        nvec++; if (d !== a) begin nfail++; $display("FAIL freeze_hold got=%h exp=%h", d, a); end
        rd(3'd7, d, v);
        nvec++; if (d !== 32'h2) begin nfail++; $display("FAIL ctrl_freeze got=%h exp=%h", d, 32'h2); end
        wr(3'd7, 32'h1, 4'hF);
        rd(3'd2, d, v);
        nvec++; if (d > 32'd3) begin nfail++; $display("FAIL clear_uptime got=%h exp<=%h", d, 32'd3); end
        rd(3'd7, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL ctrl_selfclear got=%h exp=%h", d, 32'h0); end
        wr(3'd7, 32'h3, 4'hF);
        idle(4);
        rd(3'd2, d, v);
        nvec++; if (d !== 32'h0) begin nfail++; $display("FAIL clear_freeze got=%h exp=%h", d, 32'h0); end
        wr(3'd7, 32'h0, 4'hF);
    endtask

    task automatic test_rw_collision();
        logic [31:0] d;
        logic v;
        address = 3'd4; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
        write = 1'b1; read = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0; read = 1'b0;
        nvec++; if (readdatavalid !== 1'b0) begin nfail++; $display("FAIL rw_drop_rdv got=%b exp=0", readdatavalid); end
        rd(3'd4, d, v);
        nvec++; if (d !== 32'hCAFE_F00D) begin nfail++; $display("FAIL rw_write got=%h exp=%h", d, 32'hCAFE_F00D); end
    endtask

    task automatic test_wrap33();
        dut2.uptime_q = 33'h1_FFFF_FFFF;
        address = 3'd2;
        read    = 1'b1;
        @(posedge clock);
        #1;
        nvec++; if (readdata2 !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL wrap_lo_pre got=%h exp=%h", readdata2, 32'hFFFF_FFFF); end
        @(posedge clock);
        #1;
        nvec++; if (readdata2 !== 32'h0) begin nfail++; $display("FAIL wrap_lo got=%h exp=%h", readdata2, 32'h0); end
        address = 3'd3;
        @(posedge clock);
        #1;
        read = 1'b0;
        nvec++; if (readdata2 !== 32'h0) begin nfail++; $display("FAIL wrap_hi got=%h exp=%h", readdata2, 32'h0); end
    endtask

    task automatic test_heartbeat();
        logic [31:0] d;
        logic v;
        logic hb0;
        wr(3'd7, 32'h1, 4'hF);
        hb0 = heartbeat;
`ifdef SYSID_HEARTBEAT_EN
        idle(10);
        nvec++; if (heartbeat !== ~hb0) begin nfail++; $display("FAIL hb_toggle1 got=%b exp=%b", heartbeat, ~hb0); end
        idle(10);
        nvec++; if (heartbeat !== hb0) begin nfail++; $display("FAIL hb_toggle2 got=%b exp=%b", heartbeat, hb0); end
        rd(3'd6, d, v);
        nvec++; if (d !== 32'd2) begin nfail++; $display("FAIL seconds got=%h exp=%h", d, 32'd2); end
`else
        idle(25);
        nvec++; if (heartbeat !== 1'b0) begin nfail++; $display("FAIL hb_off got=%b exp=0", heartbeat); end
        nvec++; if (hb0 !== 1'b0) begin nfail++; $display("FAIL hb_off0 got=%b exp=0", hb0); end
        rd(3'd6, d, v);
        nvec++; if (d !== 32'd0) begin nfail++; $display("FAIL seconds_off got=%h exp=%h", d, 32'd0); end
`endif
    endtask

    task automatic test_reset_midread();
        logic [31:0] d;
        logic v;
        address = 3'd0;
        read    = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        read  = 1'b0;
        reset = 1'b0;
        nvec++; if (readdatavalid !== 1'b0) begin nfail++; $display("FAIL midread_rdv got=%b exp=0", readdatavalid); end
        nvec++; if (readdata !== 32'h0) begin nfail++; $display("FAIL midread_data got=%h exp=%h", readdata, 32'h0); end
        rd(3'd4, d, v);
        nvec++; if (d !== SRST) begin nfail++; $display("FAIL midread_scratch got=%h exp=%h", d, SRST); end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 32'h0; byteenable = 4'h0;
        test_reset();
        test_id();
        test_scratch();
        test_ro_and_ctrl_bits();
        test_snapshot();
        test_freeze_clear();
        test_rw_collision();
        test_wrap33();
        test_heartbeat();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
